// File: rtl/keypad_midi_ctl_pkg.sv
// Shared types for the keypad-to-MIDI controller: FSM states, key identities
// and the priority encoder used to pick the active key.
package keypad_midi_ctl_pkg;

    localparam int MIDI_W = 7;
    localparam int KEY_N  = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT
    } state_e;

    // Encoding doubles as the bit index into the key vectors; a higher value means higher priority.
    typedef enum logic [2:0] {
        KEY_LEFT   = 3'd0,
        KEY_RIGHT  = 3'd1,
        KEY_DOWN   = 3'd2,
        KEY_UP     = 3'd3,
        KEY_CENTER = 3'd4
    } key_e;

    function automatic key_e pick_key(input logic [KEY_N-1:0] rises);
        if (rises[KEY_CENTER])     return KEY_CENTER;
        else if (rises[KEY_UP])    return KEY_UP;
        else if (rises[KEY_DOWN])  return KEY_DOWN;
        else if (rises[KEY_RIGHT]) return KEY_RIGHT;
        else                       return KEY_LEFT;
    endfunction

endpackage

// File: rtl/keypad_midi_ctl_if.sv
// Key inputs and tone/status outputs of the keypad MIDI controller.
interface keypad_midi_ctl_if #(
    parameter int C_CHANNELS = 2
);
    import keypad_midi_ctl_pkg::*;

    logic                         btn_up;
    logic                         btn_down;
    logic                         btn_left;
    logic                         btn_right;
    logic                         btn_center;
    logic [MIDI_W*C_CHANNELS-1:0] code;
    logic                         mute;
    logic                         key_evt;
    logic [7:0]                   led;

    modport master (
        output btn_up, btn_down, btn_left, btn_right, btn_center,
        input  code, mute, key_evt, led
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, btn_center,
        output code, mute, key_evt, led
    );

endinterface

// File: rtl/keypad_midi_ctl_key_debounce.sv
// One key: 2-flop synchroniser followed by a stable-count debouncer.
// rose pulses for one cycle in the same cycle that state goes high.
module key_debounce #(
    parameter int C_DEBOUNCE_CYC = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic state,
    output logic rose
);

    localparam int CW = $clog2(C_DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(C_DEBOUNCE_CYC - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            state   <= 1'b0;
            rose    <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            rose    <= 1'b0;
            // Any cycle agreeing with the current state restarts the count.
            if (sync_p1 != state) begin
                if (cnt == CNT_LAST) begin
                    state <= sync_p1;
                    rose  <= sync_p1;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/keypad_midi_ctl.sv
// Five-key keypad to multi-channel MIDI code controller with debounce,
// hold-to-repeat and mute.
module keypad_midi_ctl
    import keypad_midi_ctl_pkg::*;
#(
    parameter int C_CHANNELS         = 2,
    parameter int C_INTERVAL         = 1,
    parameter int C_MIDI_INIT        = 60,
    parameter int C_MIDI_MIN         = 0,
    parameter int C_MIDI_MAX         = 127,
    parameter int C_DEBOUNCE_CYC     = 250000,
    parameter int C_REPEAT_DELAY_CYC = 12500000,
    parameter int C_REPEAT_CYC       = 2500000
) (
    input  logic               clk,
    input  logic               rst_n,
    keypad_midi_ctl_if.slave   bus
);

    localparam int CODE_W = MIDI_W * C_CHANNELS;
    localparam int HCW    = $clog2(C_REPEAT_DELAY_CYC + 1);
    localparam int RCW    = $clog2(C_REPEAT_CYC + 1);
    localparam logic [HCW-1:0]    HOLD_LAST  = HCW'(C_REPEAT_DELAY_CYC - 1);
    localparam logic [RCW-1:0]    REP_LAST   = RCW'(C_REPEAT_CYC - 1);
    localparam logic signed [7:0] MIDI_MIN_S = 8'(C_MIDI_MIN);
    localparam logic signed [7:0] MIDI_MAX_S = 8'(C_MIDI_MAX);
    localparam logic [MIDI_W-1:0] BASE_INIT  = MIDI_W'(C_MIDI_INIT);

    function automatic logic [MIDI_W-1:0] step_base(input logic [MIDI_W-1:0] b, input key_e k);
        logic signed [7:0] cur;
        logic signed [7:0] delta;
        logic signed [7:0] sum;
        cur = $signed({1'b0, b});
        case (k)
            KEY_UP:    delta = 8'sd1;
            KEY_DOWN:  delta = -8'sd1;
            KEY_RIGHT: delta = 8'sd12;
            KEY_LEFT:  delta = -8'sd12;
            default:   delta = 8'sd0;
        endcase
        sum = cur + delta;
        // 8-bit signed wrap on a positive step means the true result is above 127.
        if (delta > 8'sd0 && sum < 8'sd0) sum = 8'sd127;
        if (sum > MIDI_MAX_S)      sum = MIDI_MAX_S;
        else if (sum < MIDI_MIN_S) sum = MIDI_MIN_S;
        return sum[MIDI_W-1:0];
    endfunction

    function automatic logic [CODE_W-1:0] chan_codes(input logic [MIDI_W-1:0] b, input logic m);
        logic [CODE_W-1:0] r;
        int                v;
        r = '0;
        for (int k = 0; k < C_CHANNELS; k++) begin
            v = int'(b) + k * C_INTERVAL;
            if (v > 127) v = 127;
            r[k*MIDI_W +: MIDI_W] = m ? '0 : MIDI_W'(v);
        end
        return r;
    endfunction

    logic [KEY_N-1:0]  raw;
    logic [KEY_N-1:0]  deb;
    logic [KEY_N-1:0]  rose;

    assign raw = {bus.btn_center, bus.btn_up, bus.btn_down, bus.btn_right, bus.btn_left};

    for (genvar i = 0; i < KEY_N; i++) begin : g_key
        key_debounce #(
            .C_DEBOUNCE_CYC(C_DEBOUNCE_CYC)
        ) u_deb (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (raw[i]),
            .state(deb[i]),
            .rose (rose[i])
        );
    end

    state_e            state;
    key_e              active;
    key_e              pick;
    key_e              act_key;
    logic              act_fire;
    logic [HCW-1:0]    hold_cnt;
    logic [RCW-1:0]    rep_cnt;
    logic [MIDI_W-1:0] base;
    logic [MIDI_W-1:0] base_nx;
    logic              mute_q;
    logic              mute_nx;
    logic              evt_q;
    logic [CODE_W-1:0] code_q;

    // Decide whether an action executes at the coming edge and what it produces.
    always_comb begin
        pick     = pick_key(rose);
        act_fire = 1'b0;
        act_key  = active;
        case (state)
            ST_IDLE: begin
                if (|rose) begin
                    act_fire = 1'b1;
                    act_key  = pick;
                end
            end
            ST_HOLD: begin
                if (deb[active] && hold_cnt == HOLD_LAST && active != KEY_CENTER) act_fire = 1'b1;
            end
            ST_REPEAT: begin
                if (deb[active] && rep_cnt == REP_LAST) act_fire = 1'b1;
            end
            default: ;
        endcase
        base_nx = base;
        mute_nx = mute_q;
        if (act_fire) begin
            if (act_key == KEY_CENTER) mute_nx = ~mute_q;
            else                       base_nx = step_base(base, act_key);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            active   <= KEY_LEFT;
            hold_cnt <= '0;
            rep_cnt  <= '0;
            base     <= BASE_INIT;
            mute_q   <= 1'b0;
            evt_q    <= 1'b0;
            code_q   <= chan_codes(BASE_INIT, 1'b0);
        end else begin
            evt_q  <= act_fire;
            base   <= base_nx;
            mute_q <= mute_nx;
            code_q <= chan_codes(base_nx, mute_nx);
            case (state)
                ST_IDLE: begin
                    if (|rose) begin
                        state    <= ST_HOLD;
                        active   <= pick;
                        hold_cnt <= '0;
                    end
                end
                ST_HOLD: begin
                    if (deb == '0) begin
                        state <= ST_IDLE;
                    end else if (deb[active]) begin
                        // Center parks here at the delay limit: it never repeats.
                        if (hold_cnt == HOLD_LAST) begin
                            if (active != KEY_CENTER) begin
                                state   <= ST_REPEAT;
                                rep_cnt <= '0;
                            end
                        end else begin
                            hold_cnt <= hold_cnt + HCW'(1);
                        end
                    end
                end
                ST_REPEAT: begin
                    if (deb == '0) begin
                        state <= ST_IDLE;
                    end else if (deb[active]) begin
                        if (rep_cnt == REP_LAST) rep_cnt <= '0;
                        else                     rep_cnt <= rep_cnt + RCW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.code    = code_q;
    assign bus.mute    = mute_q;
    assign bus.key_evt = evt_q;
    assign bus.led     = {mute_q, base};

endmodule

// File: doc/keypad_midi_ctl.md
KEYPAD_MIDI_CTL -- requirements
Module: keypad_midi_ctl

Interface
REQ-001 The block SHALL have a parameter C_CHANNELS, default 2, giving the number of output tone channels (1..8).
REQ-002 The block SHALL have a parameter C_INTERVAL, default 1, giving the semitone offset between adjacent channels.
REQ-003 The block SHALL have a parameter C_MIDI_INIT, default 60, giving the base code after reset.
REQ-004 The block SHALL have parameters C_MIDI_MIN, default 0, and C_MIDI_MAX, default 127, giving the inclusive clamp range for the base code.
REQ-005 The block SHALL have a parameter C_DEBOUNCE_CYC, default 250000, giving the stable cycles required to accept a key change (10 ms at 25 MHz).
REQ-006 The block SHALL have a parameter C_REPEAT_DELAY_CYC, default 12500000, giving the hold time before auto-repeat starts.
REQ-007 The block SHALL have a parameter C_REPEAT_CYC, default 2500000, giving the auto-repeat period.
REQ-008 Port clk, input, 1 bit: the single clock (25 MHz system clock).
REQ-009 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-010 Ports btn_up, btn_down, btn_left, btn_right, btn_center, input, 1 bit each: raw, asynchronous keys, active-high.
REQ-011 Port code, output, 7*C_CHANNELS bits: per-channel MIDI code; channel k occupies bits [7k+6:7k].
REQ-012 Port mute, output, 1 bit: high while output is muted.
REQ-013 Port key_evt, output, 1 bit: one-cycle strobe on every accepted action.
REQ-014 Port led, output, 8 bits: {mute, base code[6:0]}.

Function
REQ-015 Each key SHALL pass a 2-flop synchroniser, then an independent debouncer; the debounced state flips only after the synchronised value has differed from it for C_DEBOUNCE_CYC consecutive cycles, and any bounce restarts the count.
REQ-016 The FSM SHALL have states IDLE, HOLD and REPEAT.
REQ-017 IDLE->HOLD SHALL occur when at least one debounced key rises; the active key is the highest-priority rising key (center > up > down > right > left), and its action executes on that transition.
REQ-018 While in HOLD or REPEAT, newly pressed keys SHALL be ignored; return to IDLE occurs only when all debounced keys are low.
REQ-019 HOLD->REPEAT SHALL occur when the active key has been held C_REPEAT_DELAY_CYC cycles; the action then re-executes every C_REPEAT_CYC cycles while held; center SHALL never repeat.
REQ-020 Actions: up +1, down -1, right +12, left -12 on the base code, clamped to [C_MIDI_MIN, C_MIDI_MAX]; center toggles mute.
REQ-021 Arithmetic SHALL be done at 8 bits signed; a clamped step SHALL still assert key_evt.
REQ-022 Channel k code SHALL equal min(base + k*C_INTERVAL, 127), registered.
REQ-023 When mute=1, all code fields SHALL read 0; the base code SHALL be retained.
REQ-024 code, led and key_evt SHALL update in the cycle after the debounced edge or repeat tick: one-cycle latency.

Reset
REQ-025 While rst_n=0 at a clk edge, the block SHALL reset to: base=C_MIDI_INIT, mute=0, key_evt=0, FSM=IDLE, debounced states=0, and all counters=0.
REQ-026 Reset asserted mid-hold SHALL discard the hold; a key still held after reset SHALL be treated as a new press once it is debounced.

Structure
REQ-027 The shared package SHALL hold the FSM state enum, the key priority encoding and the MIDI width constant (7).
REQ-028 One sub-module, key_debounce (sync + counter, one key), SHALL be instantiated five times.

Verification (bench overrides: DEBOUNCE=4, DELAY=20, REPEAT=8, C_CHANNELS=3, C_INTERVAL=4)
REQ-029 Reset -> code={68,64,60}, led=0x3C, mute=0.
REQ-030 btn_up high 10 cycles with a 2-cycle glitch at start -> exactly one key_evt; base=61.
REQ-031 btn_up held 60 cycles -> events at press, +20, +28, +36, +44, +52 (approx. per counters); base=66.
REQ-032 Base 120, btn_right -> base=127, channel codes all 127, key_evt asserted.
REQ-033 btn_center and btn_down rise together -> mute=1, code=0, base unchanged; press center again -> codes restored.
REQ-034 rst_n low during REPEAT with btn_down held -> base=60 after reset; one new decrement after debounce -> 59.
